multichannel_downmix_converter: RTL and testbench
=================================================

// Module: multichannel_downmix_converter
// PURPOSE
//  Parametrised AXI-Stream N-channel to mono downmixer. Collects 2**CHANNELS_LOG2
//  interleaved channel samples per frame, outputs their average on an AXI-Stream
//  master with backpressure. Optional TLAST frame alignment with error flagging.
//  Sits between the audio packet source and the visualizer sample path.
// PARAMETERS
//  DATA_WIDTH      32  sample width, input and output
//  CHANNELS_LOG2   1   log2 of channels per frame (1 = stereo; range 0..4)
//  SIGNED_SAMPLES  1   1 = two's-complement samples, arithmetic shift; 0 = unsigned
//  ALIGN_ON_TLAST  1   1 = TLAST marks the last channel of a frame; 0 = TLAST ignored
// PORTS
//  S_AXIS_ACLK        in   1           clock, all logic rising edge
//  S_AXIS_ARESETN     in   1           reset, asynchronous, active-low
//  S_AXIS_TVALID      in   1           input beat valid
//  S_AXIS_TLAST       in   1           last channel of frame
//  S_AXIS_TDATA       in   DATA_WIDTH  channel sample
//  S_AXIS_TREADY      out  1           input beat accepted when TVALID&&TREADY
//  M_AXIS_TVALID      out  1           mono sample valid
//  M_AXIS_TREADY      in   1           downstream ready
//  M_AXIS_TDATA       out  DATA_WIDTH  mono sample
//  frame_error        out  1           one-cycle pulse per framing error
//  frame_error_count  out  16          saturating framing-error count
// BEHAVIOUR
//  Reset (async assert, sync deassert use): M_AXIS_TVALID=0, M_AXIS_TDATA=0,
//   frame_error=0, frame_error_count=0, ch_idx=0, acc=0, state=ACCUM.
//  N = 2**CHANNELS_LOG2; ACC_WIDTH = DATA_WIDTH+CHANNELS_LOG2; each beat sign-
//   (SIGNED_SAMPLES=1) or zero-extended to ACC_WIDTH; no overflow possible.
//  States: ACCUM (normal), RESYNC (discard until TLAST). RESYNC unused if
//   ALIGN_ON_TLAST=0.
//  ACCUM, accepted beat, ch_idx<N-1: acc+=beat, ch_idx++. If ALIGN_ON_TLAST and
//   TLAST=1: framing error -> acc=0, ch_idx=0, no output, stay ACCUM.
//  ACCUM, accepted beat, ch_idx==N-1: sum=acc+beat; M_AXIS_TDATA<=sum>>>CHANNELS_LOG2
//   (arith if signed, logical if unsigned, low DATA_WIDTH bits; floor rounding);
//   M_AXIS_TVALID<=1 next cycle (latency 1 from last beat); acc=0, ch_idx=0.
//   If ALIGN_ON_TLAST and TLAST=0: output still produced, framing error, ->RESYNC.
//  RESYNC: S_AXIS_TREADY=1, beats discarded, acc/ch_idx held 0; accepted beat with
//   TLAST=1 -> ACCUM (that beat also discarded).
//  Framing error: frame_error=1 for exactly one cycle; count +1, saturates 16'hFFFF.
//  Output register: single entry. Cleared (TVALID->0) when M_AXIS_TVALID&&TREADY
//   and no new result that cycle; new result and drain in same cycle -> new data,
//   TVALID stays 1. TDATA/TVALID stable while TVALID&&!TREADY.
//  S_AXIS_TREADY (combinational) = 0 only when state=ACCUM, ch_idx==N-1 and
//   M_AXIS_TVALID&&!M_AXIS_TREADY; 1 otherwise. Full throughput: one beat/cycle.
//  N=1 (CHANNELS_LOG2=0): every beat is pass-through, latency 1; TLAST=0 with
//   ALIGN_ON_TLAST=1 is an error on every beat.
//  Reset mid-frame: partial accumulation and pending output discarded.
// TESTING
//  Stereo unsigned, 0x10 then 0x20(TLAST) -> M_AXIS_TDATA=0x18, TVALID 1 cycle later.
//  Stereo signed, 0xFFFFFFFC then 0x00000002 -> 0xFFFFFFFF (-1, floor); unsigned
//   build 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF (no wrap).
//  CHANNELS_LOG2=2, beats 1,2,3,6(TLAST) -> 0x3; back-to-back 8 frames, TVALID
//   every 4 cycles, no input stall with M_AXIS_TREADY=1.
//  M_AXIS_TREADY=0, two stereo frames -> 2nd frame's R beat stalls (TREADY=0),
//   first output held stable; TREADY up -> both outputs in order, none lost.
//  TLAST on L beat -> frame_error pulse, count=1, no output; next good frame
//   ok. R without TLAST -> output, error, next 3 beats dropped until TLAST.
//  Assert S_AXIS_ARESETN=0 after L beat -> all outputs reset value immediately;
//   next frame after release averages correctly.

Source files
------------

// File: rtl/multichannel_downmix_converter.sv
// multichannel_downmix_converter
//   AXI-Stream N-channel to mono downmixer. Collects 2**CHANNELS_LOG2 interleaved
//   channel samples per frame and emits their floor-average on a single-entry
//   AXI-Stream master register with backpressure. When ALIGN_ON_TLAST is set,
//   TLAST must coincide with the last channel of each frame; violations pulse
//   frame_error, bump a saturating counter and (for a missing TLAST) discard
//   input until the next TLAST.
//
// Ports
//   S_AXIS_ACLK        clock, rising edge
//   S_AXIS_ARESETN     asynchronous active-low reset
//   S_AXIS_TVALID/TLAST/TDATA/TREADY  channel-sample slave stream
//   M_AXIS_TVALID/TREADY/TDATA        mono-sample master stream
//   frame_error        one-cycle pulse per framing error
//   frame_error_count  saturating 16-bit framing-error count
module multichannel_downmix_converter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CHANNELS_LOG2  = 1,
  parameter bit          SIGNED_SAMPLES = 1'b1,
  parameter bit          ALIGN_ON_TLAST = 1'b1
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  S_AXIS_TREADY,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  frame_error,
  output logic [15:0]           frame_error_count
);

  localparam int unsigned N    = 1 << CHANNELS_LOG2;
  localparam int unsigned AccW = DATA_WIDTH + CHANNELS_LOG2;
  // Keep the index at least one bit wide so the N=1 build still elaborates.
  localparam int unsigned IdxW = (CHANNELS_LOG2 == 0) ? 1 : CHANNELS_LOG2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [0:0] {StAccum, StResync} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ch_idx_q, ch_idx_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  ferr_q, ferr_d;
  logic [15:0]           ferr_cnt_q, ferr_cnt_d;

  logic [AccW-1:0]       beat_ext;
  logic [AccW-1:0]       sum;
  logic [DATA_WIDTH-1:0] result;
  logic                  last_ch;
  logic                  accept;

  // Accumulator is wide enough for N full-scale samples, so the sum never wraps.
  generate
    if (SIGNED_SAMPLES) begin : g_signed
      assign beat_ext = AccW'($signed(S_AXIS_TDATA));
      assign sum      = acc_q + beat_ext;
      assign result   = DATA_WIDTH'($signed(sum) >>> CHANNELS_LOG2);
    end else begin : g_unsigned
      assign beat_ext = AccW'(S_AXIS_TDATA);
      assign sum      = acc_q + beat_ext;
      assign result   = DATA_WIDTH'(sum >> CHANNELS_LOG2);
    end
  endgenerate

  assign last_ch = (ch_idx_q == LastIdx);

  // Only the frame-completing beat needs a free output slot; all others flow.
  assign S_AXIS_TREADY = !((state_q == StAccum) && last_ch && m_valid_q && !M_AXIS_TREADY);
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    acc_d      = acc_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    ferr_d     = 1'b0;
    ferr_cnt_d = ferr_cnt_q;

    // Drain first; a new result below overrides so valid stays high.
    if (m_valid_q && M_AXIS_TREADY) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      StAccum: begin
        if (accept) begin
          if (last_ch) begin
            m_valid_d = 1'b1;
            m_data_d  = result;
            acc_d     = '0;
            ch_idx_d  = '0;
            if (ALIGN_ON_TLAST && !S_AXIS_TLAST) begin
              ferr_d  = 1'b1;
              state_d = StResync;
            end
          end else if (ALIGN_ON_TLAST && S_AXIS_TLAST) begin
            // Early TLAST: drop the partial frame, realign on the next beat.
            ferr_d   = 1'b1;
            acc_d    = '0;
            ch_idx_d = '0;
          end else begin
            acc_d    = sum;
            ch_idx_d = ch_idx_q + IdxW'(1);
          end
        end
      end
      StResync: begin
        acc_d    = '0;
        ch_idx_d = '0;
        if (accept && S_AXIS_TLAST) begin
          state_d = StAccum;
        end
      end
      default: begin
        state_d  = StAccum;
        acc_d    = '0;
        ch_idx_d = '0;
      end
    endcase

    if (ferr_d && (ferr_cnt_q != 16'hFFFF)) begin
      ferr_cnt_d = ferr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q    <= StAccum;
      ch_idx_q   <= '0;
      acc_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      ferr_q     <= 1'b0;
      ferr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_idx_q   <= ch_idx_d;
      acc_q      <= acc_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      ferr_q     <= ferr_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  assign M_AXIS_TVALID     = m_valid_q;
  assign M_AXIS_TDATA      = m_data_q;
  assign frame_error       = ferr_q;
  assign frame_error_count = ferr_cnt_q;

endmodule

// File: tb/tb_multichannel_downmix_converter.sv
// Directed bench: four builds share one input stream.
//   0: stereo unsigned, 1: stereo signed, 2: 4-channel signed, 3: mono unsigned
module tb_multichannel_downmix_converter;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_last;
  logic [31:0] s_data;
  logic        m_ready;

  logic        s_ready [4];
  logic        m_valid [4];
  logic [31:0] m_data  [4];
  logic        ferr    [4];
  logic [15:0] fcnt    [4];

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multichannel_downmix_converter #(
    .DATA_WIDTH(32), .CHANNELS_LOG2(1), .SIGNED_SAMPLES(1'b0), .ALIGN_ON_TLAST(1'b1)
  ) u_dut0 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TVALID(s_valid),
    .S_AXIS_TLAST(s_last), .S_AXIS_TDATA(s_data), .S_AXIS_TREADY(s_ready[0]),
    .M_AXIS_TVALID(m_valid[0]), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data[0]),
    .frame_error(ferr[0]), .frame_error_count(fcnt[0])
  );

  multichannel_downmix_converter #(
    .DATA_WIDTH(32), .CHANNELS_LOG2(1), .SIGNED_SAMPLES(1'b1), .ALIGN_ON_TLAST(1'b1)
  ) u_dut1 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TVALID(s_valid),
    .S_AXIS_TLAST(s_last), .S_AXIS_TDATA(s_data), .S_AXIS_TREADY(s_ready[1]),
    .M_AXIS_TVALID(m_valid[1]), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data[1]),
    .frame_error(ferr[1]), .frame_error_count(fcnt[1])
  );

  multichannel_downmix_converter #(
    .DATA_WIDTH(32), .CHANNELS_LOG2(2), .SIGNED_SAMPLES(1'b1), .ALIGN_ON_TLAST(1'b1)
  ) u_dut2 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TVALID(s_valid),
    .S_AXIS_TLAST(s_last), .S_AXIS_TDATA(s_data), .S_AXIS_TREADY(s_ready[2]),
    .M_AXIS_TVALID(m_valid[2]), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data[2]),
    .frame_error(ferr[2]), .frame_error_count(fcnt[2])
  );

  multichannel_downmix_converter #(
    .DATA_WIDTH(32), .CHANNELS_LOG2(0), .SIGNED_SAMPLES(1'b0), .ALIGN_ON_TLAST(1'b1)
  ) u_dut3 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TVALID(s_valid),
    .S_AXIS_TLAST(s_last), .S_AXIS_TDATA(s_data), .S_AXIS_TREADY(s_ready[3]),
    .M_AXIS_TVALID(m_valid[3]), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data[3]),
    .frame_error(ferr[3]), .frame_error_count(fcnt[3])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present one beat to build `sel`, wait (bounded) for acceptance; returns at edge+1.
  task automatic send(input int sel, input logic [31:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  initial begin
    int t0;
    do_reset();
    chk("rst_mvalid", 32'(m_valid[1]), 32'd0);
    chk("rst_mdata", m_data[1], 32'd0);
    chk("rst_ferr", 32'(ferr[1]), 32'd0);
    chk("rst_fcnt", 32'(fcnt[1]), 32'd0);
    chk("rst_sready", 32'(s_ready[2]), 32'd1);

    // Stereo unsigned average with latency 1.
    send(0, 32'h10, 1'b0);
    chk("st_u_mid_valid", 32'(m_valid[0]), 32'd0);
    send(0, 32'h20, 1'b1);
    chk("st_u_valid", 32'(m_valid[0]), 32'd1);
    chk("st_u_data", m_data[0], 32'h18);
    @(posedge clk); #1;
    chk("st_u_drained", 32'(m_valid[0]), 32'd0);

    // Signed floor and unsigned no-wrap.
    do_reset();
    send(1, 32'hFFFF_FFFC, 1'b0);
    send(1, 32'h0000_0002, 1'b1);
    chk("st_s_floor", m_data[1], 32'hFFFF_FFFF);
    do_reset();
    send(0, 32'hFFFF_FFFF, 1'b0);
    send(0, 32'hFFFF_FFFF, 1'b1);
    chk("st_u_nowrap", m_data[0], 32'hFFFF_FFFF);

    // Four channels, then 8 back-to-back frames at one beat per cycle.
    do_reset();
    send(2, 32'd1, 1'b0);
    send(2, 32'd2, 1'b0);
    send(2, 32'd3, 1'b0);
    send(2, 32'd6, 1'b1);
    chk("q_data", m_data[2], 32'd3);
    t0 = cyc;
    for (int f = 0; f < 8; f++) begin
      for (int b = 0; b < 4; b++) begin
        send(2, 32'(4 * f + b), (b == 3));
        if (b == 0) chk("q_gap_valid", 32'(m_valid[2]), 32'd0);
      end
      chk("q_b2b_data", m_data[2], 32'(4 * f + 1));
    end
    chk("q_b2b_cycles", 32'(cyc - t0), 32'd32);

    // Backpressure: second frame's R beat stalls, first output held.
    do_reset();
    m_ready = 1'b0;
    send(0, 32'd1, 1'b0);
    send(0, 32'd3, 1'b1);
    send(0, 32'd5, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'd7;
    s_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall", 32'(s_ready[0]), 32'd0);
      chk("bp_hold", m_data[0], 32'd2);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(s_ready[0]), 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    chk("bp_second_valid", 32'(m_valid[0]), 32'd1);
    chk("bp_second_data", m_data[0], 32'd6);
    @(posedge clk); #1;
    chk("bp_empty", 32'(m_valid[0]), 32'd0);

    // Framing errors: early TLAST, then missing TLAST with resync.
    do_reset();
    send(0, 32'h10, 1'b1);
    chk("fe_early_pulse", 32'(ferr[0]), 32'd1);
    chk("fe_early_cnt", 32'(fcnt[0]), 32'd1);
    chk("fe_early_noout", 32'(m_valid[0]), 32'd0);
    @(posedge clk); #1;
    chk("fe_pulse_end", 32'(ferr[0]), 32'd0);
    send(0, 32'd4, 1'b0);
    send(0, 32'd8, 1'b1);
    chk("fe_good_data", m_data[0], 32'd6);
    send(0, 32'd2, 1'b0);
    send(0, 32'd4, 1'b0);
    chk("fe_late_data", m_data[0], 32'd3);
    chk("fe_late_pulse", 32'(ferr[0]), 32'd1);
    chk("fe_late_cnt", 32'(fcnt[0]), 32'd2);
    send(0, 32'd100, 1'b0);
    send(0, 32'd200, 1'b0);
    send(0, 32'd300, 1'b1);
    chk("fe_drop_noout", 32'(m_valid[0]), 32'd0);
    chk("fe_drop_cnt", 32'(fcnt[0]), 32'd2);
    send(0, 32'd10, 1'b0);
    send(0, 32'd20, 1'b1);
    chk("fe_resync_data", m_data[0], 32'd15);

    // Asynchronous reset mid-frame with a pending output.
    do_reset();
    send(0, 32'd1, 1'b1);
    m_ready = 1'b0;
    send(0, 32'd2, 1'b0);
    send(0, 32'd4, 1'b1);
    chk("ar_pending", m_data[0], 32'd3);
    send(0, 32'h100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mvalid", 32'(m_valid[0]), 32'd0);
    chk("ar_mdata", m_data[0], 32'd0);
    chk("ar_fcnt", 32'(fcnt[0]), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    send(0, 32'd6, 1'b0);
    send(0, 32'd10, 1'b1);
    chk("ar_after", m_data[0], 32'd8);

    // Mono build: pass-through, every beat without TLAST is an error.
    do_reset();
    send(3, 32'h1234, 1'b1);
    chk("mono_data", m_data[3], 32'h1234);
    chk("mono_ok", 32'(ferr[3]), 32'd0);
    send(3, 32'h55, 1'b0);
    chk("mono_data2", m_data[3], 32'h55);
    chk("mono_err", 32'(ferr[3]), 32'd1);
    chk("mono_cnt", 32'(fcnt[3]), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
